// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the encodings used by the sprite overlay path.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;

  typedef enum logic [1:0] {
    HIDDEN = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

endpackage

// File: rtl/sprite_axis_mover.sv
// One axis of the bouncing sprite: position and direction, clamped to [0, LIMIT-SIZE],
// advanced by STEP on each frame tick while running.
module sprite_axis_mover #(
  parameter int LIMIT = 640,
  parameter int SIZE  = 32,
  parameter int STEP  = 2,
  parameter int INIT  = 100
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       i_tick,
  input  logic       i_run,
  input  logic       i_load,
  output logic [9:0] o_pos,
  output logic       o_bounce
);

  import vga_pkg::*;

  localparam logic [10:0] MAX_POS  = 11'(LIMIT - SIZE);
  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [9:0]  INIT_POS = 10'(INIT);

  logic [9:0]  r_pos;
  dir_t        r_dir;
  logic [10:0] w_pos11;
  logic [10:0] w_fwd;
  logic        w_hitHigh;
  logic        w_hitLow;
  logic        w_move;
  logic [9:0]  w_nextPos;
  dir_t        w_nextDir;

  // 11-bit intermediates keep pos+STEP from wrapping near the far edge
  assign w_pos11   = {1'b0, r_pos};
  assign w_fwd     = w_pos11 + STEP_W;
  assign w_hitHigh = (w_fwd >= MAX_POS);
  assign w_hitLow  = (w_pos11 <= STEP_W);
  assign w_move    = i_tick && i_run && !i_load;

  always_comb begin
    w_nextPos = r_pos;
    w_nextDir = r_dir;
    o_bounce  = 1'b0;
    if (i_load) begin
      w_nextPos = INIT_POS;
      w_nextDir = DIR_POS;
    end else if (w_move) begin
      if (r_dir == DIR_POS) begin
        if (w_hitHigh) begin
          w_nextPos = MAX_POS[9:0];
          w_nextDir = DIR_NEG;
          o_bounce  = 1'b1;
        end else begin
          w_nextPos = w_fwd[9:0];
        end
      end else begin
        if (w_hitLow) begin
          w_nextPos = '0;
          w_nextDir = DIR_POS;
          o_bounce  = 1'b1;
        end else begin
          w_nextPos = r_pos - STEP_W[9:0];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pos <= INIT_POS;
      r_dir <= DIR_POS;
    end else begin
      r_pos <= w_nextPos;
      r_dir <= w_nextDir;
    end
  end

  assign o_pos = r_pos;

endmodule

// File: rtl/vga_sprite_overlay.sv
// Pixel-path stage that overlays a bouncing solid-colour square on the generator stream
// and delays sync by one cycle to stay aligned with the overlaid colour.
module vga_sprite_overlay #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32,
  parameter int STEP     = 2,
  parameter int X0       = 100,
  parameter int Y0       = 60
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [9:0] HDATA,
  input  logic [9:0] VDATA,
  input  logic       R_IN,
  input  logic       G_IN,
  input  logic       B_IN,
  input  logic       HSYNC_IN,
  input  logic       VSYNC_IN,
  input  logic       ENABLE,
  input  logic       FREEZE,
  input  logic [2:0] COLOR,
  output logic       R,
  output logic       G,
  output logic       B,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       ON_SPRITE,
  output logic [7:0] BOUNCE_CNT
);

  import vga_pkg::*;

  state_t     r_state;
  state_t     w_nextState;
  logic [9:0] r_hdD;
  logic [9:0] r_vdD;
  logic       r_prevMatch;
  logic [2:0] r_rgb;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_onSprite;
  logic [7:0] r_bounceCnt;

  logic       w_match;
  logic       w_tick;
  logic       w_run;
  logic       w_load;
  logic [9:0] w_xPos;
  logic [9:0] w_yPos;
  logic       w_bounceX;
  logic       w_bounceY;
  logic       w_inActive;
  logic       w_inX;
  logic       w_inY;
  logic       w_hit;

  // First pixel of the first blanking line; edge-detected so it lasts exactly one cycle
  assign w_match = (HDATA == 10'd0) && (VDATA == 10'(V_ACTIVE));
  assign w_tick  = w_match && !r_prevMatch;
  assign w_run   = (r_state == RUN);
  assign w_load  = !ENABLE;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= HIDDEN;
      r_prevMatch <= 1'b0;
      r_hdD       <= '0;
      r_vdD       <= '0;
    end else begin
      r_state     <= w_nextState;
      r_prevMatch <= w_match;
      r_hdD       <= HDATA;
      r_vdD       <= VDATA;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      HIDDEN: if (ENABLE) w_nextState = FREEZE ? FROZEN : RUN;
      RUN: begin
        if (!ENABLE)     w_nextState = HIDDEN;
        else if (FREEZE) w_nextState = FROZEN;
      end
      FROZEN: begin
        if (!ENABLE)      w_nextState = HIDDEN;
        else if (!FREEZE) w_nextState = RUN;
      end
      default: w_nextState = HIDDEN;
    endcase
  end

  sprite_axis_mover #(
    .LIMIT (H_ACTIVE),
    .SIZE  (SPR_W),
    .STEP  (STEP),
    .INIT  (X0)
  ) u_moverX (
    .CLK      (CLK),
    .RESET    (RESET),
    .i_tick   (w_tick),
    .i_run    (w_run),
    .i_load   (w_load),
    .o_pos    (w_xPos),
    .o_bounce (w_bounceX)
  );

  sprite_axis_mover #(
    .LIMIT (V_ACTIVE),
    .SIZE  (SPR_H),
    .STEP  (STEP),
    .INIT  (Y0)
  ) u_moverY (
    .CLK      (CLK),
    .RESET    (RESET),
    .i_tick   (w_tick),
    .i_run    (w_run),
    .i_load   (w_load),
    .o_pos    (w_yPos),
    .o_bounce (w_bounceY)
  );

  // A corner hit bounces both axes in one tick but counts as a single bounce frame
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bounceCnt <= '0;
    end else if (w_bounceX || w_bounceY) begin
      r_bounceCnt <= r_bounceCnt + 8'd1;
    end
  end

  assign w_inActive = (r_hdD < 10'(H_ACTIVE)) && (r_vdD < 10'(V_ACTIVE));
  assign w_inX = ({1'b0, r_hdD} >= {1'b0, w_xPos}) &&
                 ({1'b0, r_hdD} <  ({1'b0, w_xPos} + 11'(SPR_W)));
  assign w_inY = ({1'b0, r_vdD} >= {1'b0, w_yPos}) &&
                 ({1'b0, r_vdD} <  ({1'b0, w_yPos} + 11'(SPR_H)));
  assign w_hit = (r_state != HIDDEN) && w_inActive && w_inX && w_inY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rgb      <= 3'b000;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_onSprite <= 1'b0;
    end else begin
      r_hsync    <= HSYNC_IN;
      r_vsync    <= VSYNC_IN;
      r_onSprite <= w_hit;
      if (w_hit) begin
        r_rgb <= COLOR;
      end else if (w_inActive) begin
        r_rgb <= {R_IN, G_IN, B_IN};
      end else begin
        r_rgb <= 3'b000;
      end
    end
  end

  assign R          = r_rgb[2];
  assign G          = r_rgb[1];
  assign B          = r_rgb[0];
  assign HSYNC      = r_hsync;
  assign VSYNC      = r_vsync;
  assign ON_SPRITE  = r_onSprite;
  assign BOUNCE_CNT = r_bounceCnt;

endmodule

// File: tb/tb_vga_sprite_overlay.sv
// Directed bench for vga_sprite_overlay: three instances with different start points and
// sprite sizes share one stimulus stream so edge, corner and wrap cases come up quickly.
module tb_vga_sprite_overlay;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [9:0] HDATA;
  logic [9:0] VDATA;
  logic       R_IN, G_IN, B_IN;
  logic       HSYNC_IN, VSYNC_IN;
  logic       ENABLE, FREEZE;
  logic [2:0] COLOR;

  logic       rA, gA, bA, hsA, vsA, onA;
  logic [7:0] cntA;
  logic       rB, gB, bB, hsB, vsB, onB;
  logic [7:0] cntB;
  logic       rC, gC, bC, hsC, vsC, onC;
  logic [7:0] cntC;

  int vectors = 0;
  int miscompares = 0;

  always #20 CLK = ~CLK;

  vga_sprite_overlay dutA (
    .CLK(CLK), .RESET(RESET), .HDATA(HDATA), .VDATA(VDATA),
    .R_IN(R_IN), .G_IN(G_IN), .B_IN(B_IN), .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
    .ENABLE(ENABLE), .FREEZE(FREEZE), .COLOR(COLOR),
    .R(rA), .G(gA), .B(bA), .HSYNC(hsA), .VSYNC(vsA), .ON_SPRITE(onA), .BOUNCE_CNT(cntA)
  );

  vga_sprite_overlay #(.X0(604), .Y0(444)) dutB (
    .CLK(CLK), .RESET(RESET), .HDATA(HDATA), .VDATA(VDATA),
    .R_IN(R_IN), .G_IN(G_IN), .B_IN(B_IN), .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
    .ENABLE(ENABLE), .FREEZE(FREEZE), .COLOR(COLOR),
    .R(rB), .G(gB), .B(bB), .HSYNC(hsB), .VSYNC(vsB), .ON_SPRITE(onB), .BOUNCE_CNT(cntB)
  );

  // Large sprite leaves a tiny travel range (X 0..24, Y 0..16) so bounces are frequent
  vga_sprite_overlay #(.SPR_W(616), .SPR_H(464), .X0(20), .Y0(10)) dutC (
    .CLK(CLK), .RESET(RESET), .HDATA(HDATA), .VDATA(VDATA),
    .R_IN(R_IN), .G_IN(G_IN), .B_IN(B_IN), .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
    .ENABLE(ENABLE), .FREEZE(FREEZE), .COLOR(COLOR),
    .R(rC), .G(gC), .B(bC), .HSYNC(hsC), .VSYNC(vsC), .ON_SPRITE(onC), .BOUNCE_CNT(cntC)
  );

  task automatic checkOutput(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic onOf(input int idx);
    case (idx)
      0:       onOf = onA;
      1:       onOf = onB;
      default: onOf = onC;
    endcase
  endfunction

  // Drive a pixel address, then its colour one cycle later; outputs are valid after that
  task automatic applyStimulus(input int h, input int v, input logic [2:0] rgbIn);
    @(negedge CLK);
    HDATA = 10'(h);
    VDATA = 10'(v);
    @(negedge CLK);
    {R_IN, G_IN, B_IN} = rgbIn;
    @(negedge CLK);
  endtask

  task automatic frameTick(input logic en);
    @(negedge CLK);
    HDATA  = 10'd0;
    VDATA  = 10'd480;
    ENABLE = en;
    @(negedge CLK);
    HDATA  = 10'd1;
  endtask

  // Sprite top-left is at (x,y) exactly when that pixel is lit and its left/upper neighbours are not
  task automatic checkCorner(input string tag, input int idx, input int x, input int y);
    applyStimulus(x, y, 3'b000);
    checkOutput({tag, "_in"}, 32'(onOf(idx)), 1);
    if (x > 0) begin
      applyStimulus(x - 1, y, 3'b000);
      checkOutput({tag, "_left"}, 32'(onOf(idx)), 0);
    end
    if (y > 0) begin
      applyStimulus(x, y - 1, 3'b000);
      checkOutput({tag, "_up"}, 32'(onOf(idx)), 0);
    end
  endtask

  initial begin
    logic [3:0] vsPat;
    int cx, cy, cdx, cdy, ccnt;
    logic bnc;

    RESET = 1'b1; ENABLE = 1'b0; FREEZE = 1'b0; COLOR = 3'b101;
    HDATA = 10'd700; VDATA = 10'd10;
    {R_IN, G_IN, B_IN} = 3'b111; HSYNC_IN = 1'b0; VSYNC_IN = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_rgb", 32'({rA, gA, bA}), 0);
    checkOutput("rst_hsync", 32'(hsA), 1);
    checkOutput("rst_vsync", 32'(vsA), 1);
    checkOutput("rst_on", 32'(onA), 0);
    checkOutput("rst_cnt", 32'(cntA), 0);

    RESET = 1'b0; ENABLE = 1'b1; HSYNC_IN = 1'b1; VSYNC_IN = 1'b1;
    {R_IN, G_IN, B_IN} = 3'b000;

    for (int t = 1; t <= 10; t++) begin
      frameTick(1'b1);
      if (t == 1) begin
        checkCorner("b_t1", 1, 606, 446);
        checkOutput("b_cnt_t1", 32'(cntB), 0);
      end
      if (t == 2) begin
        checkCorner("b_t2", 1, 608, 448);
        checkOutput("b_cnt_corner", 32'(cntB), 1);
      end
      if (t == 3) checkCorner("b_t3", 1, 606, 446);
    end
    checkCorner("a_10f", 0, 120, 80);
    checkOutput("a_cnt_10f", 32'(cntA), 0);
    applyStimulus(120, 80, 3'b010);
    checkOutput("a_draw_rgb", 32'({rA, gA, bA}), 5);
    applyStimulus(152, 80, 3'b010);
    checkOutput("a_right_on", 32'(onA), 0);
    checkOutput("a_right_rgb", 32'({rA, gA, bA}), 2);
    applyStimulus(151, 111, 3'b000);
    checkOutput("a_br_on", 32'(onA), 1);
    applyStimulus(151, 112, 3'b000);
    checkOutput("a_below_on", 32'(onA), 0);

    @(negedge CLK); FREEZE = 1'b1;
    for (int t = 0; t < 5; t++) frameTick(1'b1);
    checkCorner("a_frozen", 0, 120, 80);
    COLOR = 3'b110;
    applyStimulus(125, 85, 3'b001);
    checkOutput("a_frozen_rgb", 32'({rA, gA, bA}), 6);

    @(negedge CLK); ENABLE = 1'b0; FREEZE = 1'b0;
    applyStimulus(120, 80, 3'b011);
    checkOutput("hid_on", 32'(onA), 0);
    checkOutput("hid_rgb", 32'({rA, gA, bA}), 3);
    applyStimulus(700, 10, 3'b111);
    checkOutput("hid_hblank", 32'({rA, gA, bA}), 0);
    applyStimulus(10, 500, 3'b111);
    checkOutput("hid_vblank", 32'({rA, gA, bA}), 0);
    @(negedge CLK); ENABLE = 1'b1;
    checkCorner("a_reenable", 0, 100, 60);
    checkOutput("b_cnt_kept", 32'(cntB), 1);

    for (int t = 0; t < 3; t++) frameTick(1'b1);
    checkCorner("a_3f", 0, 106, 66);
    frameTick(1'b0);
    frameTick(1'b1);
    checkCorner("a_en_edges", 0, 100, 60);
    frameTick(1'b1);
    checkCorner("a_after_rise", 0, 102, 62);

    @(negedge CLK); HDATA = 10'd659; VDATA = 10'd100; HSYNC_IN = 1'b0;
    checkOutput("hs_pre", 32'(hsA), 1);
    @(negedge CLK); HDATA = 10'd755; HSYNC_IN = 1'b1;
    checkOutput("hs_fall", 32'(hsA), 0);
    @(negedge CLK);
    checkOutput("hs_rise", 32'(hsA), 1);
    vsPat = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      VSYNC_IN = vsPat[i];
      if (i > 0) checkOutput("vs_delay", 32'(vsA), 32'(vsPat[i - 1]));
    end
    @(negedge CLK);
    checkOutput("vs_delay_last", 32'(vsA), 32'(vsPat[3]));
    VSYNC_IN = 1'b1;
    applyStimulus(639, 10, 3'b111);
    checkOutput("edge_h639", 32'({rA, gA, bA}), 7);
    applyStimulus(640, 10, 3'b111);
    checkOutput("edge_h640", 32'({rA, gA, bA}), 0);
    applyStimulus(300, 479, 3'b111);
    checkOutput("edge_v479", 32'({rA, gA, bA}), 7);
    applyStimulus(300, 480, 3'b111);
    checkOutput("edge_v480", 32'({rA, gA, bA}), 0);

    @(negedge CLK);
    HDATA = 10'd0; VDATA = 10'd480; RESET = 1'b1; ENABLE = 1'b0; HSYNC_IN = 1'b0;
    @(negedge CLK);
    checkOutput("rtick_hsync", 32'(hsA), 1);
    checkOutput("rtick_rgb", 32'({rA, gA, bA}), 0);
    checkOutput("rtick_on", 32'(onA), 0);
    checkOutput("rtick_cntB", 32'(cntB), 0);
    RESET = 1'b0; HSYNC_IN = 1'b1; HDATA = 10'd1;
    applyStimulus(100, 60, 3'b000);
    checkOutput("rtick_hidden", 32'(onA), 0);
    @(negedge CLK); ENABLE = 1'b1;
    checkCorner("a_rst_pos", 0, 100, 60);

    for (int t = 1; t <= 559; t++) begin
      frameTick(1'b1);
      if (t == 193) checkOutput("a_cnt_193", 32'(cntA), 0);
      if (t == 194) begin
        checkCorner("a_ybot", 0, 488, 448);
        checkOutput("a_cnt_194", 32'(cntA), 1);
      end
      if (t == 254) begin
        checkCorner("a_xright", 0, 608, 328);
        checkOutput("a_cnt_254", 32'(cntA), 2);
      end
      if (t == 255) checkCorner("a_t255", 0, 606, 326);
      if (t == 557) begin
        checkCorner("a_t557", 0, 2, 278);
        checkOutput("a_cnt_557", 32'(cntA), 3);
      end
      if (t == 558) begin
        checkCorner("a_xleft", 0, 0, 280);
        checkOutput("a_cnt_558", 32'(cntA), 4);
      end
      if (t == 559) checkCorner("a_t559", 0, 2, 282);
    end

    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    cx = 20; cy = 10; cdx = 0; cdy = 0; ccnt = 0;
    for (int k = 0; k < 3000 && ccnt < 256; k++) begin
      frameTick(1'b1);
      bnc = 1'b0;
      if (cdx == 0) begin
        if (cx + 2 >= 24) begin cx = 24; cdx = 1; bnc = 1'b1; end
        else cx = cx + 2;
      end else begin
        if (cx <= 2) begin cx = 0; cdx = 0; bnc = 1'b1; end
        else cx = cx - 2;
      end
      if (cdy == 0) begin
        if (cy + 2 >= 16) begin cy = 16; cdy = 1; bnc = 1'b1; end
        else cy = cy + 2;
      end else begin
        if (cy <= 2) begin cy = 0; cdy = 0; bnc = 1'b1; end
        else cy = cy - 2;
      end
      if (bnc) ccnt++;
      checkOutput("c_cnt", 32'(cntC), ccnt % 256);
    end
    checkOutput("c_wrap", 32'(cntC), 0);
    checkCorner("c_pos", 2, cx, cy);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
